// File: rtl/neuron_pkg.sv
// Shared types and saturating arithmetic helpers for the neuron MAC core.
// The helpers operate on the fixed DATA_W / ACC_W widths defined here, so
// the core's dataWidth parameter must stay equal to DATA_W.
package neuron_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    BIAS  = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Saturating signed add at accumulator width: compute one guard bit wider
  // and clamp when the guard bit disagrees with the result sign bit.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    return s[ACC_W-1:0];
  endfunction

  // Saturate an accumulator-width value down to data width. The value fits
  // only when every bit above the data sign bit matches that sign bit.
  function automatic logic signed [DATA_W-1:0] sat_narrow(
    input logic signed [ACC_W-1:0] x
  );
    logic [ACC_W-DATA_W:0] top;
    top = x[ACC_W-1:DATA_W-1];
    if ((&top) || (~|top)) begin
      return x[DATA_W-1:0];
    end
    return x[ACC_W-1] ? DATA_MIN : DATA_MAX;
  endfunction

endpackage

// File: rtl/neuron_mac_sat_accumulator.sv
// Clearable saturating signed accumulator with an add-enable.
// Clear has priority over add; the accumulator never wraps.
module sat_accumulator
  import neuron_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add_en,
  input  logic signed [ACC_W-1:0] addend,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // Next accumulator value: clear, saturating add, or hold.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = sat_add(acc_q, addend);
    end
  end

  // Accumulator register; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/neuron_mac.sv
// Multiply-accumulate neuron core fed by Weight_Memory.
// Each accepted input issues one weight read; the weight returns a cycle
// later, is multiplied (stage p1) and accumulated with saturation. After the
// last input the FSM drains the pipe, adds the bias, and emits ReLU(result).
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int numWeight    = 3,
  parameter int addressWidth = 16,
  parameter int dataWidth    = DATA_W,
  parameter int fracWidth    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [dataWidth-1:0]    in_data,
  output logic                           ren,
  output logic        [addressWidth-1:0] radd,
  input  logic signed [dataWidth-1:0]    wout,
  input  logic signed [dataWidth-1:0]    bias,
  output logic                           out_valid,
  output logic signed [dataWidth-1:0]    out_data
);

  localparam int CNT_W = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(numWeight - 1);

  // Control state
  state_e                  state_d,     state_q;
  logic [CNT_W-1:0]        cnt_d,       cnt_q;
  logic                    vld_p0_d,    vld_p0_q;
  logic                    vld_p1_d,    vld_p1_q;
  logic                    out_valid_d, out_valid_q;
  logic signed [dataWidth-1:0] out_data_d, out_data_q;

  // Datapath registers (not reset; qualified by the valid bits)
  logic signed [dataWidth-1:0] in_p0_d,  in_p0_q;
  logic signed [ACC_W-1:0]     prod_p1_d, prod_p1_q;

  // Accumulator interface
  logic                    acc_clr;
  logic                    acc_add_en;
  logic signed [ACC_W-1:0] acc_addend;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_scaled;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [dataWidth-1:0] result_sat;

  // Input handshake and weight read are combinational so the read address
  // lines up with the accepting edge.
  assign in_ready = (state_q == ACCUM) && !rst;
  assign ren      = in_valid && in_ready;
  assign radd     = addressWidth'(cnt_q);

  // Bias is aligned to the product's binary point (2*fracWidth fraction bits).
  assign bias_scaled = ACC_W'(bias) <<< fracWidth;
  assign acc_shr     = acc >>> fracWidth;
  assign result_sat  = sat_narrow(acc_shr);

  // ---- Stage p0: capture accepted input alongside its weight read ----
  always_comb begin
    in_p0_d  = ren ? in_data : in_p0_q;
    vld_p0_d = ren;
  end

  // ---- Stage p1: full-precision product of input and returned weight ----
  always_comb begin
    prod_p1_d = ACC_W'(in_p0_q) * ACC_W'(wout);
    vld_p1_d  = vld_p0_q;
  end

  // ---- Stage p2: accumulate products, or the bias while in BIAS ----
  always_comb begin
    acc_add_en = vld_p1_q || (state_q == BIAS);
    acc_addend = (state_q == BIAS) ? bias_scaled : prod_p1_q;
  end

  // FSM next-state, weight counter and registered output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    acc_clr     = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (ren) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        // Once p0 is empty, the final product is being accumulated this
        // cycle, so the accumulator is complete when BIAS begins.
        if (!vld_p0_q) begin
          state_d = BIAS;
        end
      end
      BIAS: begin
        state_d = OUT;
      end
      OUT: begin
        out_valid_d = 1'b1;
        out_data_d  = result_sat[dataWidth-1] ? '0 : result_sat;
        acc_clr     = 1'b1;
        state_d     = ACCUM;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // FSM, counter, valid bits and output registers (reset-controlled).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Datapath pipeline registers.
  always_ff @(posedge clk) begin
    in_p0_q   <= in_p0_d;
    prod_p1_q <= prod_p1_d;
  end

  sat_accumulator u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .add_en (acc_add_en),
    .addend (acc_addend),
    .acc    (acc)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
Multiply-accumulate neuron core that sits directly downstream of Weight_Memory.
- Accepts a stream of numWeight input activations and issues one weight read per input (ren/radd).
- Multiplies each input by the returned weight (wout) and accumulates with saturation.
- Adds a bias, applies ReLU, and emits one dataWidth result per input vector.

Parameters:
numWeight, 3, inputs/weights per neuron; vector length.
addressWidth, 16, width of weight read address; must match Weight_Memory.
dataWidth, 16, signed fixed-point width of inputs, weights, bias and output.
fracWidth, 8, fractional bits of the signed fixed-point format (Q(dataWidth-fracWidth).fracWidth).

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  core can accept an input this cycle.
in_data  input  dataWidth  signed input activation.
ren  output  1  weight read enable to Weight_Memory.
radd  output  addressWidth  weight read address.
wout  input  dataWidth  signed weight; valid in the cycle after ren.
bias  input  dataWidth  signed bias; held stable by the parent; sampled in BIAS state.
out_valid  output  1  one-cycle pulse; out_data valid.
out_data  output  dataWidth  signed ReLU output.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered except ren/radd/in_ready.
- Reset values:
  - state=ACCUM, weight counter=0, accumulator=0, pipeline valid bits=0.
  - out_valid=0, out_data=0.
  - in_ready=0 and ren=0 while rst is high.
- Accept: an input is accepted when in_valid && in_ready.
  - ren = in_valid && in_ready (combinational).
  - radd = weight counter, zero-extended to addressWidth.
  - Same edge: in_data registered, counter increments.
- Read latency: 1 cycle. wout is consumed in the cycle after acceptance.
- Stage P (accept+1): product = in_reg * wout.
  - Full 2*dataWidth signed product, registered with a valid bit.
- Stage A (accept+2): acc = sat(acc + product).
  - Accumulator is 2*dataWidth signed and saturates to the max/min representable value; no wrap.
- FSM states: ACCUM, DRAIN, BIAS, OUT.
  - ACCUM: in_ready=1. On acceptance of input numWeight-1: counter wraps to 0 and state goes to DRAIN.
  - DRAIN: in_ready=0. Stay until product and accumulate stages are empty (2 cycles), then go to BIAS.
  - BIAS: acc = sat(acc + (sign-extended bias <<< fracWidth)). Next state OUT.
  - OUT: compute r = acc >>> fracWidth (arithmetic), saturate to dataWidth signed, then ReLU (r<0 -> 0). Register out_data, pulse out_valid for exactly 1 cycle, clear acc, return to ACCUM.
- Latency: out_valid is high 5 cycles after the cycle in which the last input was accepted.
  - in_ready rises again in the cycle out_valid is high, so back-to-back vectors are supported.
- Gaps: in_valid may drop between inputs. Accumulation order and addresses are unaffected; radd only advances on acceptance.
- Back-pressure: none on output. out_data holds its last value until the next out_valid.
- Reset mid-operation: the partial vector is discarded and no out_valid is produced. The next accepted input reads radd=0.
- numWeight=1: the first acceptance goes directly to DRAIN.

Decomposition:
- Shared package neuron_pkg holds:
  - state enum (ACCUM, DRAIN, BIAS, OUT)
  - function sat_narrow (2*dataWidth to dataWidth signed saturation)
  - function sat_add (saturating signed add)
  - constant ACC_W = 2*dataWidth
- One natural sub-module: sat_accumulator. It provides a clearable saturating signed accumulator with an add-enable. neuron_mac instantiates it and drives it from both the accumulate stage and the BIAS state.

Test Plan:
- Basic dot product:
  - Stimulus: inputs 0x0100, 0x0200, 0x0300 (1.0, 2.0, 3.0); weights 0x0080 x3 (0.5); bias 0x0100.
  - Required: out_data=0x0400 (4.0); out_valid pulse exactly 5 cycles after the last accept; radd sequence 0,1,2, each with ren=1.
- ReLU clamp:
  - Stimulus: same inputs; weights 0xFF00 (-1.0); bias 0.
  - Required: internal result -6.0; out_data=0x0000 with out_valid=1.
- Saturation:
  - Stimulus: inputs 0x7F00 x3; weights 0x7F00 x3; bias 0x7FFF.
  - Required: accumulator pins at 0x7FFFFFFF; out_data=0x7FFF; no wrap to negative.
- Gapped and back-to-back vectors:
  - Stimulus: in_valid low for 2 cycles between inputs of vector 1, then vector 2 presented immediately when in_ready rises.
  - Required: correct results for both vectors; radd restarts at 0; in_ready=0 for exactly the 4 cycles following the last accept.
- Reset mid-vector:
  - Stimulus: 2 inputs accepted, rst pulsed 1 cycle, then the full basic vector.
  - Required: no out_valid for the aborted vector; following result = 0x0400; first radd after reset = 0.
